// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter that drains a show-ahead byte FIFO.
// Each byte is popped with a single-cycle read strobe, then framed as a
// start bit, pDataWidth data bits (LSB first) and one stop bit, each held
// for pClksPerBit iClk cycles. When another byte is waiting at the end of
// the stop bit, the next frame starts immediately with no idle gap.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> an even-parity bit goes between the last data bit and the
//                stop bit (8E1, 11 bit periods per frame)
//   undefined -> no parity state or parity logic (8N1, 10 bit periods)
//
// Reset is synchronous and active-high (iRst). All outputs come straight
// from flops.

module uart_tx #(
    parameter int pClksPerBit = 104,
    parameter int pDataWidth  = 8
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iFifoEmpty,
    input  logic [pDataWidth-1:0] iFifoData,
    output logic                  oFifoReadEn,
    output logic                  oTx,
    output logic                  oBusy
);

    // Bit timer counts 0..pClksPerBit-1; bit index counts data bits sent.
    localparam int CNT_W = $clog2(pClksPerBit);
    localparam int IDX_W = $clog2(pDataWidth + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(pClksPerBit - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(pDataWidth - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

`ifdef UART_TX_PARITY_EN
    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [pDataWidth-1:0] data);
        even_parity = ^data;
    endfunction
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t                  state_q,  state_d;
    logic [CNT_W-1:0]        cnt_q,    cnt_d;
    logic [IDX_W-1:0]        idx_q,    idx_d;
    logic [pDataWidth-1:0]   shift_q,  shift_d;
    logic                    tx_q,     tx_d;
    logic                    busy_q,   busy_d;
    logic                    rd_en_q,  rd_en_d;
`ifdef UART_TX_PARITY_EN
    logic                    par_q,    par_d;
`endif

    // End of the current bit period.
    logic bit_end_s;
    assign bit_end_s = (cnt_q == BIT_LAST);

    // Next-state, datapath and output logic for the framing FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        rd_en_d = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif

        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                idx_d  = '0;
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (!iFifoEmpty) begin
                    // Capture the head word now; the pop strobe follows
                    // on the next cycle from the registered output.
                    shift_d = iFifoData;
`ifdef UART_TX_PARITY_EN
                    par_d   = even_parity(iFifoData);
`endif
                    rd_en_d = 1'b1;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_START: begin
                if (bit_end_s) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end

            S_DATA: begin
                if (bit_end_s) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = S_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        // Shift right so the next bit sits in position 0.
                        shift_d = shift_q >> 1;
                        tx_d    = shift_d[0];
                        idx_d   = idx_q + IDX_ONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end_s) begin
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
`endif

            S_STOP: begin
                if (bit_end_s) begin
                    cnt_d = '0;
                    idx_d = '0;
                    if (!iFifoEmpty) begin
                        // Back-to-back: start the next frame with no gap.
                        shift_d = iFifoData;
`ifdef UART_TX_PARITY_EN
                        par_d   = even_parity(iFifoData);
`endif
                        rd_en_d = 1'b1;
                        tx_d    = 1'b0;
                        busy_d  = 1'b1;
                        state_d = S_START;
                    end else begin
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                cnt_d   = '0;
                idx_d   = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset wins over any pop.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            rd_en_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            rd_en_q <= rd_en_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign oTx         = tx_q;
    assign oBusy       = busy_q;
    assign oFifoReadEn = rd_en_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter that drains a synchronous show-ahead byte FIFO and serializes each byte onto a single TX line. It is the read side of the UART TX path. Upstream logic writes bytes into the FIFO; this block pops them one at a time and frames each as 8N1, or 8E1 when parity is compiled in. It runs in the single iClk domain with the FIFO.

## Interface
Parameters:
- pClksPerBit, 104 — iClk cycles per bit period (12 MHz / 115200). Must be ≥ 2.
- pDataWidth, 8 — data bits per frame; must match the FIFO data width.

Ports:
- iClk  in  1  system clock.
- iRst  in  1  reset: iRst, synchronous, active-high; clock iClk.
- iFifoEmpty  in  1  FIFO empty flag; 1 means no byte is available.
- iFifoData  in  pDataWidth  FIFO head word; valid whenever iFifoEmpty=0.
- oFifoReadEn  out  1  one-cycle pop strobe to the FIFO.
- oTx  out  1  serial line; idles high.
- oBusy  out  1  high while a frame is on the line.

## Operation
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE:
  - oTx=1, oBusy=0.
  - On an edge where iFifoEmpty=0: latch iFifoData into the shift register, pulse oFifoReadEn for the following cycle, go to START.
- START: oTx=0 for pClksPerBit cycles, then go to DATA.
- DATA:
  - oTx = shift[0], LSB first.
  - Each bit is held pClksPerBit cycles, then the register shifts right.
  - After pDataWidth bits, go to PARITY if enabled, else STOP.
- PARITY: oTx = XOR of the latched byte (even parity) for pClksPerBit cycles.
- STOP:
  - oTx=1 for pClksPerBit cycles.
  - On the last stop cycle: if iFifoEmpty=0, latch the next byte, pulse oFifoReadEn and go directly to START (back-to-back frames, no idle gap). Otherwise go to IDLE.
- Bit timer: a counter of width $clog2(pClksPerBit) counts 0..pClksPerBit-1 and wraps to 0 at each bit boundary. Bit index counter has width $clog2(pDataWidth+1).
- Exactly one oFifoReadEn pulse per transmitted byte. Never pulse while iFifoEmpty=1.
- iFifoEmpty and iFifoData are ignored outside IDLE and the last STOP cycle.

## Timing
- Reset values: oTx=1, oFifoReadEn=0, oBusy=0; state IDLE; counters 0.
- All outputs are registered.
- Latency: for iFifoEmpty sampled 0 at edge N in IDLE, oTx falls and oBusy rises after edge N. oFifoReadEn is high for exactly cycle N..N+1.
- Frame length: (2 + pDataWidth) × pClksPerBit cycles, plus pClksPerBit with parity. This is 10×104 = 1040 cycles at defaults.
- oBusy stays high continuously across back-to-back frames.
- The FIFO empty flag updates one cycle after the pop. The block does not sample it again until the next frame end, so there is no double-pop hazard.
- Reset mid-frame: the next cycle oTx=1, oBusy=0, state IDLE. The partially sent byte is lost; it has already been popped and is not re-read.
- iRst takes priority over a same-cycle pop condition: no oFifoReadEn is issued.

## Configuration
- UART_TX_PARITY_EN:
  - Defined: the PARITY state is compiled in and each frame carries an even-parity bit between the last data bit and the stop bit (8E1, 11 bit periods).
  - Undefined: the PARITY state and XOR logic are absent (8N1, 10 bit periods).

## Test plan
- Reset, FIFO empty → oTx=1, oBusy=0, oFifoReadEn=0 held for 50 cycles; no pops.
- pClksPerBit=4, FIFO holds 0x55, iFifoEmpty falls → oTx = 0,1,0,1,0,1,0,1,0,1. Each level lasts 4 cycles (40 cycles total). One oFifoReadEn pulse one cycle after capture. oBusy high for 40 cycles.
- pClksPerBit=4, bytes 0xA3 then 0x0F queued → two contiguous frames with no idle cycle between them. Exactly 2 pops. oBusy high for 80 consecutive cycles.
- UART_TX_PARITY_EN defined, pClksPerBit=4, bytes 0x07 then 0x55 → parity bits 1 and 0 respectively. Each frame is 44 cycles.
- Assert iRst for 1 cycle at cycle 17 of a 0xFF frame → oTx=1 and oBusy=0 next cycle. No additional pop. A later byte 0x81 then transmits correctly.
- pClksPerBit=2 (minimum), byte 0x80 → each bit is 2 cycles. The MSB appears as the last data bit, high for cycles 16–17 after the start edge, followed by 2 stop cycles.
